// File: rtl/uart_echo_master_if.sv
// Shared system bus: a master raises req with address/data and holds it until
// the slave answers with a single-cycle ack (rdata is valid with ack on reads).
interface bus_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req;
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  ack;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/uart_echo_master.sv
// UART echo master: buffers received bytes in a local FIFO, mirrors them on the
// 7-segment display and echoes them back. Optional macro UART_ECHO_CRLF_EN adds LF after CR.

module biu_master #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_out,
    input  logic                  rnw,
    output logic                  busy,
    output logic                  data_valid,
    output logic [DATA_WIDTH-1:0] data_in,
    bus_if.master                 bus
);
    logic                  pending;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pending    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            data_valid <= 1'b0;
            data_in    <= '0;
        end else begin
            data_valid <= 1'b0;
            if (!pending) begin
                if (en) begin
                    pending <= 1'b1;
                    we_q    <= ~rnw;
                    addr_q  <= address;
                    wdata_q <= data_out;
                end
            end else if (bus.ack) begin
                pending <= 1'b0;
                if (!we_q) begin
                    data_valid <= 1'b1;
                    data_in    <= bus.rdata;
                end
            end
        end
    end

    assign busy      = pending;
    assign bus.req   = pending;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;
endmodule

module uart_echo_master #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] UART_BASE  = 32'hc000_0000,
    parameter logic [ADDR_WIDTH-1:0] SEG7_BASE  = 32'hc000_1000,
    parameter int                    DATA_BITS  = 8,
    parameter int                    BUF_DEPTH  = 8,
    parameter int                    CNT_WIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        n_rst,
    bus_if.master                       bus,
    output logic [CNT_WIDTH-1:0]        o_rx_count,
    output logic [CNT_WIDTH-1:0]        o_tx_count,
    output logic [$clog2(BUF_DEPTH):0]  o_fifo_level
);
    localparam int PTR_W = $clog2(BUF_DEPTH) + 1;
    localparam int IDX_W = PTR_W - 1;
    localparam logic [ADDR_WIDTH-1:0] UART_STAT = UART_BASE + ADDR_WIDTH'(8);

`ifdef UART_ECHO_CRLF_EN
    typedef enum logic [5:0] {
        IDLE = 6'b000001, STAT = 6'b000010, RXRD = 6'b000100,
        S7WR = 6'b001000, TXWR = 6'b010000, TXLF = 6'b100000
    } state_t;
`else
    typedef enum logic [4:0] {
        IDLE = 5'b00001, STAT = 5'b00010, RXRD = 5'b00100,
        S7WR = 5'b01000, TXWR = 5'b10000
    } state_t;
`endif

    typedef enum logic {RR_RX = 1'b0, RR_TX = 1'b1} rr_t;

    state_t state, state_nxt;
    rr_t    rr_last;
    logic   issued, rearm;
    logic   push, pop, tx_inc;

    logic                  biu_en, biu_rnw, biu_busy, biu_data_valid;
    logic [ADDR_WIDTH-1:0] biu_addr;
    logic [DATA_WIDTH-1:0] biu_wdata, biu_data_in;
    logic [DATA_WIDTH-1:0] history;

    logic [7:0]       fifo_mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic             fifo_empty, fifo_full;
    logic [7:0]       fifo_head, rx_byte;
    logic             rd_done, can_rx, can_tx;
    logic             unused_data;

`ifdef UART_ECHO_CRLF_EN
    logic lf_write, lf_write_nxt;
`endif

    biu_master #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_biu (
        .clk        (clk),
        .n_rst      (n_rst),
        .en         (biu_en),
        .address    (biu_addr),
        .data_out   (biu_wdata),
        .rnw        (biu_rnw),
        .busy       (biu_busy),
        .data_valid (biu_data_valid),
        .data_in    (biu_data_in),
        .bus        (bus)
    );

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                        (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]);
    assign fifo_head  = fifo_mem[rd_ptr[IDX_W-1:0]];

    // A read result belongs to this state only once its own request went out.
    assign rd_done     = issued & biu_data_valid;
    assign can_rx      = ~biu_data_in[0] & ~fifo_full;
    assign can_tx      = ~biu_data_in[1] & ~fifo_empty;
    assign unused_data = ^{biu_data_in, 1'b0};

    always_comb begin
        rx_byte                = '0;
        rx_byte[DATA_BITS-1:0] = biu_data_in[DATA_BITS-1:0];
    end

    // NOTE: every output of this block is given a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_nxt = state;
        biu_en    = 1'b0;
        biu_rnw   = 1'b0;
        biu_addr  = '0;
        biu_wdata = '0;
        push      = 1'b0;
        pop       = 1'b0;
        tx_inc    = 1'b0;
        rearm     = 1'b0;
`ifdef UART_ECHO_CRLF_EN
        lf_write_nxt = lf_write;
`endif
        unique case (state)
            IDLE: state_nxt = STAT;
            STAT: begin
                biu_en   = ~issued & ~biu_busy;
                biu_rnw  = 1'b1;
                biu_addr = UART_STAT;
                if (rd_done) begin
                    if (can_rx && (!can_tx || rr_last == RR_TX)) state_nxt = RXRD;
                    else if (can_tx)                               state_nxt = TXWR;
                    else                                           state_nxt = IDLE;
                end
            end
            RXRD: begin
                biu_en   = ~issued & ~biu_busy;
                biu_rnw  = 1'b1;
                biu_addr = UART_BASE;
                if (rd_done) begin
                    push      = 1'b1;
                    state_nxt = S7WR;
                end
            end
            S7WR: begin
                biu_en    = ~issued & ~biu_busy;
                biu_addr  = SEG7_BASE;
                biu_wdata = history;
                if (biu_en) state_nxt = IDLE;
            end
            TXWR: begin
                biu_en    = ~issued & ~biu_busy;
                biu_addr  = UART_BASE;
                biu_wdata = DATA_WIDTH'(fifo_head);
                if (biu_en) begin
                    pop       = 1'b1;
                    tx_inc    = 1'b1;
                    state_nxt = IDLE;
`ifdef UART_ECHO_CRLF_EN
                    if (fifo_head == 8'h0d) state_nxt = TXLF;
`endif
                end
            end
`ifdef UART_ECHO_CRLF_EN
            TXLF: begin
                biu_en = ~issued & ~biu_busy;
                if (!lf_write) begin
                    // Poll status until the TX side has room for the LF.
                    biu_rnw  = 1'b1;
                    biu_addr = UART_STAT;
                    if (rd_done) begin
                        rearm = 1'b1;
                        if (!biu_data_in[1]) lf_write_nxt = 1'b1;
                    end
                end else begin
                    biu_addr  = UART_BASE;
                    biu_wdata = DATA_WIDTH'(8'h0a);
                    if (biu_en) begin
                        tx_inc       = 1'b1;
                        lf_write_nxt = 1'b0;
                        state_nxt    = IDLE;
                    end
                end
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            issued       <= 1'b0;
            rr_last      <= RR_TX;
            history      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_fifo_level <= '0;
            o_rx_count   <= '0;
            o_tx_count   <= '0;
`ifdef UART_ECHO_CRLF_EN
            lf_write     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef UART_ECHO_CRLF_EN
            lf_write <= lf_write_nxt;
`endif
            if (state_nxt != state || rearm) issued <= 1'b0;
            else if (biu_en)                 issued <= 1'b1;

            if (push) begin
                wr_ptr       <= wr_ptr + PTR_W'(1);
                history      <= {history[DATA_WIDTH-9:0], rx_byte};
                o_rx_count   <= o_rx_count + CNT_WIDTH'(1);
                o_fifo_level <= o_fifo_level + PTR_W'(1);
                rr_last      <= RR_RX;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                o_fifo_level <= o_fifo_level - PTR_W'(1);
                rr_last      <= RR_TX;
            end
            if (tx_inc) o_tx_count <= o_tx_count + CNT_WIDTH'(1);
        end
    end

    // NOTE: the FIFO array has no reset; the pointers define which entries are
    // valid, and keeping storage out of the reset net lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[IDX_W-1:0]] <= rx_byte;
    end
endmodule

// File: tb/tb_uart_echo_master.sv
// Directed bench for uart_echo_master: a behavioural UART + 7-segment slave on the
// bus, hand-computed expectations for echo, burst, round-robin, reset and wrap cases.
module tb_uart_echo_master;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int CW    = 4;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam logic [31:0] UART_BASE = 32'hc000_0000;
    localparam logic [31:0] UART_STAT = 32'hc000_0008;
    localparam logic [31:0] SEG7_BASE = 32'hc000_1000;

    logic          clk   = 1'b0;
    logic          n_rst = 1'b0;
    logic [CW-1:0] rx_count, tx_count;
    logic [LW-1:0] fifo_level;

    bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    uart_echo_master #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .UART_BASE(UART_BASE), .SEG7_BASE(SEG7_BASE),
        .DATA_BITS(8), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .bus          (bus),
        .o_rx_count   (rx_count),
        .o_tx_count   (tx_count),
        .o_fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    // Slave model state: rx_mem/rx_wr owned by the stimulus, the rest by the slave.
    logic [7:0]  rx_mem [256];
    int          rx_wr       = 0;
    int          rx_rd       = 0;
    logic        tx_full     = 1'b0;
    logic        stall_rx    = 1'b0;
    logic        late_ack    = 1'b0;
    logic [7:0]  tx_log [$];
    logic [7:0]  op_log [$];
    logic [31:0] seg7_last   = '0;
    int          full_reads  = 0;
    int          empty_reads = 0;

    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            bus.ack   <= 1'b0;
            bus.rdata <= '0;
        end else begin
            bus.ack <= 1'b0;
            if (late_ack) begin
                bus.ack <= 1'b1;
            end else if (bus.req && !bus.ack &&
                         !(stall_rx && !bus.we && bus.addr == UART_BASE)) begin
                bus.ack <= 1'b1;
                if (bus.we) begin
                    if (bus.addr == UART_BASE) begin
                        tx_log.push_back(bus.wdata[7:0]);
                        op_log.push_back(8'h54);
                    end else if (bus.addr == SEG7_BASE) begin
                        seg7_last = bus.wdata;
                    end
                end else if (bus.addr == UART_STAT) begin
                    bus.rdata <= {30'b0, tx_full, rx_rd == rx_wr};
                end else if (bus.addr == UART_BASE) begin
                    if (rx_rd == rx_wr) empty_reads++;
                    if (int'(fifo_level) == DEPTH) full_reads++;
                    bus.rdata <= {24'b0, rx_mem[rx_rd[7:0]]};
                    rx_rd++;
                    op_log.push_back(8'h52);
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_rst = 1'b1;
    endtask

    task automatic push_rx(input logic [7:0] b);
        rx_mem[rx_wr[7:0]] = b;
        rx_wr++;
    endtask

    function automatic logic [7:0] tx_at(input int idx);
        if (idx < tx_log.size()) return tx_log[idx];
        return 8'hee;
    endfunction

    initial begin
        int    base, obase;
        bit    found;
        string rr_exp;

        // Reset values and single-byte echo.
        do_reset();
        check("reset_rx_count", 32'(rx_count), 0);
        check("reset_tx_count", 32'(tx_count), 0);
        check("reset_level", 32'(fifo_level), 0);
        base = tx_log.size();
        push_rx(8'h41);
        cycles(200);
        check("single_seg7", seg7_last, 32'h0000_0041);
        check("single_tx_n", 32'(tx_log.size() - base), 1);
        check("single_tx_byte", 32'(tx_at(base)), 32'h41);
        check("single_rx_count", 32'(rx_count), 1);
        check("single_tx_count", 32'(tx_count), 1);
        check("single_level", 32'(fifo_level), 0);

        // Burst of ten bytes with TX held full, then released.
        do_reset();
        tx_full = 1'b1;
        base    = tx_log.size();
        for (int i = 0; i < 10; i++) push_rx(8'h30 + 8'(i));
        cycles(400);
        check("burst_level_full", 32'(fifo_level), 8);
        check("burst_rx_count", 32'(rx_count), 8);
        check("burst_history", seg7_last, 32'h3435_3637);
        check("burst_no_tx", 32'(tx_log.size() - base), 0);
        check("burst_full_reads", 32'(full_reads), 0);
        tx_full = 1'b0;
        cycles(600);
        check("drain_tx_n", 32'(tx_log.size() - base), 10);
        for (int i = 0; i < 10; i++)
            check($sformatf("drain_tx_%0d", i), 32'(tx_at(base + i)), 32'h30 + 32'(i));
        check("drain_rx_count", 32'(rx_count), 10);
        check("drain_tx_count", 32'(tx_count), 10);
        check("drain_level", 32'(fifo_level), 0);
        check("drain_history", seg7_last, 32'h3637_3839);

        // Round-robin: RX and TX alternate once both are possible.
        do_reset();
        base   = tx_log.size();
        obase  = op_log.size();
        rr_exp = "RTRTRT";
        for (int i = 0; i < 3; i++) push_rx(8'h61 + 8'(i));
        cycles(300);
        check("rr_ops_n", 32'(op_log.size() - obase), 6);
        for (int i = 0; i < 6; i++)
            if (obase + i < op_log.size())
                check($sformatf("rr_op_%0d", i), 32'(op_log[obase + i]), 32'(rr_exp[i]));
        for (int i = 0; i < 3; i++)
            check($sformatf("rr_tx_%0d", i), 32'(tx_at(base + i)), 32'h61 + 32'(i));
        check("rr_rx_count", 32'(rx_count), 3);

        // Reset while an RX data read is outstanding.
        stall_rx = 1'b1;
        push_rx(8'h55);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(posedge clk);
            #1;
            if (bus.req && !bus.we && bus.addr == UART_BASE) found = 1'b1;
        end
        check("midrd_seen", 32'(found), 1);
        cycles(2);
        n_rst = 1'b0;
        #1;
        check("midrd_rx_count", 32'(rx_count), 0);
        check("midrd_tx_count", 32'(tx_count), 0);
        check("midrd_level", 32'(fifo_level), 0);
        check("midrd_req", 32'(bus.req), 0);
        rx_wr    = rx_rd;
        stall_rx = 1'b0;
        late_ack = 1'b1;
        n_rst    = 1'b1;
        @(posedge clk);
        #1;
        late_ack = 1'b0;
        cycles(100);
        check("late_ack_rx_count", 32'(rx_count), 0);
        check("late_ack_level", 32'(fifo_level), 0);

        // Counter wrap at 2^CW.
        do_reset();
        base = tx_log.size();
        for (int i = 0; i < 17; i++) push_rx(8'h80 + 8'(i));
        cycles(900);
        check("wrap_rx_count", 32'(rx_count), 1);
        check("wrap_tx_count", 32'(tx_count), 1);
        check("wrap_tx_n", 32'(tx_log.size() - base), 17);
        check("wrap_last_tx", 32'(tx_at(base + 16)), 32'h90);
        check("wrap_level", 32'(fifo_level), 0);

        // Carriage return handling.
        do_reset();
        base = tx_log.size();
        push_rx(8'h0d);
        cycles(200);
        check("cr_tx_byte", 32'(tx_at(base)), 32'h0d);
        check("cr_seg7", seg7_last, 32'h0000_000d);
`ifdef UART_ECHO_CRLF_EN
        check("crlf_tx_n", 32'(tx_log.size() - base), 2);
        check("crlf_lf_byte", 32'(tx_at(base + 1)), 32'h0a);
        check("crlf_tx_count", 32'(tx_count), 2);
`else
        check("cr_tx_n", 32'(tx_log.size() - base), 1);
        check("cr_tx_count", 32'(tx_count), 1);
`endif
        check("cr_level", 32'(fifo_level), 0);

        check("no_empty_rx_reads", 32'(empty_reads), 0);
        check("no_full_rx_reads", 32'(full_reads), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_echo_master.md
Name: uart_echo_master

Overview:
- Parametrised successor to the single-byte UART echo test master.
- Bus master that moves received UART bytes into a local FIFO of depth BUF_DEPTH, mirrors a rolling history of received bytes on the 7-segment controller, and drains the FIFO back to the UART TX.
- Round-robin arbitration between RX and TX, so bursts are decoupled from TX back-pressure.
- Sits at top level beside uart_controller and seg7_controller on the shared bus_if, through an internal biu_master instance.

Parameters:
- ADDR_WIDTH, 32, bus address width.
- DATA_WIDTH, 32, bus data width; must be a multiple of 8.
- UART_BASE, 32'hc0000000, UART slave base: data register at +0, status register at +8.
- SEG7_BASE, 32'hc0001000, 7-segment slave data register.
- DATA_BITS, 8, UART character width (1..8).
- BUF_DEPTH, 8, local FIFO depth; power of 2, at least 2.
- CNT_WIDTH, 16, width of the statistics counters.

Ports:
- clk  in  1  clock
- n_rst  in  1  asynchronous active-low reset
- bus  interface  bus_if(ADDR_WIDTH, DATA_WIDTH)  system bus, driven through the internal biu_master
- o_rx_count  out  CNT_WIDTH  bytes read from UART RX; wraps
- o_tx_count  out  CNT_WIDTH  bytes written to UART TX; wraps
- o_fifo_level  out  $clog2(BUF_DEPTH)+1  current local FIFO occupancy

Behaviour:
- Reset is n_rst, asynchronous, active-low; clock is clk.
- Reset values:
  - state = IDLE; all counters 0; FIFO empty; history 0; rr_last = TX.
  - biu en=0, address=0, data_out=0, rnw=0.
- BIU handshake:
  - A request is issued in the cycle en=1 and busy=0.
  - A write completes at issue.
  - A read completes in the cycle data_valid=1; data_in is sampled then.
  - en is held low while busy=1.
  - Exactly one request is issued per state visit.
- Status register bits: [0] = rx_empty, [1] = tx_full.
- States (one-hot):
  - IDLE: go to STAT next cycle.
  - STAT: read UART_BASE+8; on data_valid, latch rx_empty and tx_full, then decide:
    - can_rx = ~rx_empty & ~fifo_full
    - can_tx = ~tx_full & ~fifo_empty
    - If both are set, serve the side opposite rr_last.
    - Else serve whichever is set.
    - Else return to IDLE.
  - RXRD: read UART_BASE; on data_valid:
    - push data_in[DATA_BITS-1:0] (zero-extended to 8 bits) into the FIFO;
    - history <= {history[DATA_WIDTH-9:0], byte};
    - o_rx_count++; rr_last = RX; go to S7WR.
  - S7WR: write history to SEG7_BASE; go to IDLE.
  - TXWR: write the FIFO head, zero-extended, to UART_BASE; at issue, pop the FIFO, o_tx_count++, rr_last = TX; go to IDLE (or TXLF, see optional feature).
- FIFO:
  - Circular, pointers of $clog2(BUF_DEPTH)+1 bits.
  - Full when the MSBs differ and the low bits are equal.
  - Push and pop never happen in the same cycle: the FSM serialises them.
- Boundary conditions:
  - FIFO full: RX is not served even when rx_empty=0; characters accumulate in the UART's own FIFO.
  - FIFO empty: TX is not served.
  - Counters wrap from 2^CNT_WIDTH-1 to 0.
  - Stale status: status is re-read before every data transfer; no RX read is issued without a fresh rx_empty=0.
  - Reset mid-transaction: everything returns to reset values immediately; the outstanding biu read is abandoned and any later data_valid is ignored in IDLE.
  - o_fifo_level is registered; it updates the cycle after a push or pop.

Optional Feature:
- Macro: UART_ECHO_CRLF_EN.
- Defined:
  - A TXWR that sends 0x0D moves to TXLF instead of IDLE.
  - TXLF reads status and repeats until tx_full=0, then writes 0x0A to UART_BASE.
  - o_tx_count increments for the 0x0A as well; no FIFO pop; then IDLE.
- Undefined: TXLF does not exist and bytes are echoed verbatim.

Test Plan:
- Single byte: UART RX 0x41 -> seg7 write 0x00000041, TX 0x41, o_rx_count=1, o_tx_count=1, level returns to 0.
- Burst with TX held full: 10 bytes 0x30..0x39 arrive while tx_full=1 -> level saturates at 8, no RX read while full, history=0x34353637. Release TX -> 0x30..0x37 are sent in order, then 0x38, 0x39; rx_count=tx_count=10.
- Round-robin: rx_empty=0 and tx_full=0 with FIFO non-empty -> RXRD and TXWR alternate, starting with RX after reset.
- Reset mid-read: assert n_rst while in RXRD with busy=1 -> outputs and counters are 0 immediately; the late data_valid causes no push.
- Counter wrap: with CNT_WIDTH=4, 17 bytes -> o_rx_count=1.
- UART_ECHO_CRLF_EN: RX 0x0D -> TX 0x0D then 0x0A, o_tx_count=2; without the macro only 0x0D is sent, o_tx_count=1.
